// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, R/W bit and ACK/NACK line levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_target_state_t;

  // Value of the R/W bit that follows the 7-bit address.
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // SDA level during the ninth (acknowledge) clock.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Register-bank strobe interface between the I2C target and the fabric register bank.
// slave: the I2C target side. master: the register bank side.
interface i2c_target_if;
  logic [7:0] reg_addr_out;  // current pointer, also the read address
  logic [7:0] rd_data_in;    // register contents at reg_addr_out
  logic       wr_valid_out;  // one-cycle write strobe
  logic [7:0] wr_data_out;   // write data, address is reg_addr_out
  logic       busy_out;      // addressed transaction in progress

  modport slave (
    output reg_addr_out,
    output wr_valid_out,
    output wr_data_out,
    output busy_out,
    input  rd_data_in
  );

  modport master (
    input  reg_addr_out,
    input  wr_valid_out,
    input  wr_data_out,
    input  busy_out,
    output rd_data_in
  );
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer and bus-event detector. Produces single-cycle SCL edge,
// START and STOP pulses from the synchronized pin levels, plus the synchronized SDA.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains plus one history flop per line for edge detection.
  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each stage capture its neighbour's pre-edge value.
      scl_sync_q[0] <= scl_in;
      sda_sync_q[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  // SDA transitions only count as START/STOP while SCL is stable high.
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;
  assign sda_sync  =  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address decode, one-byte register pointer, byte writes
// to and reads from an external register bank over an open-drain SDA.
// Optional feature macro: I2C_TARGET_AUTOINC_EN (pointer auto-increment).
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         scl_in,
  inout  wire          sda,
  i2c_target_if.slave  bus
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [7:0] LAST_PTR = 8'(NUM_REGS - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .scl_in    (scl_in),
    .sda_in    (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_sync  (sda_sync)
  );

  i2c_target_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;   // 8 bits collected, waiting for the ACK slot
  logic [7:0] shift_q, shift_d;           // receive shifter
  logic [7:0] tx_q, tx_d;                 // transmit shifter, MSB is on the line
  logic       sda_oe_q, sda_oe_d;         // 1 = pull SDA low
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;               // controller's ACK bit after a read byte
  logic [7:0] reg_addr_q, reg_addr_d;
  logic       ptr_valid_q, ptr_valid_d;   // pointer is below NUM_REGS
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       busy_q, busy_d;
  logic       advance;

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  assign rx_byte = {shift_q[6:0], sda_sync};
  // An out-of-range pointer reads as all ones, which leaves SDA released.
  assign rd_byte = ptr_valid_q ? bus.rd_data_in : 8'hFF;

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      tx_q        <= 8'hFF;
      // NOTE: the SDA enable sits on the async reset so the line frees the instant reset asserts.
      sda_oe_q    <= 1'b0;
      rw_q        <= I2C_WRITE;
      ack_q       <= I2C_NACK;
      reg_addr_q  <= 8'h00;
      ptr_valid_q <= 1'b1;
      wr_data_q   <= 8'h00;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      reg_addr_q  <= reg_addr_d;
      ptr_valid_q <= ptr_valid_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: STOP beats START beats SCL edges; sample on rise, drive on fall.
  always_comb begin
    // NOTE: every variable is defaulted first so no path through this block can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    reg_addr_d  = reg_addr_q;
    ptr_valid_d = ptr_valid_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    busy_d      = busy_q;
    advance     = 1'b0;

    if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      byte_done_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (!byte_done_q) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              byte_done_d = 1'b1;
              if (state_q == PTR) begin
                reg_addr_d  = rx_byte;
                ptr_valid_d = ({1'b0, rx_byte} < 9'(NUM_REGS));
              end
              if (state_q == WDATA && ptr_valid_q) begin
                wr_data_d  = rx_byte;
                wr_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        RDATA_ACK: begin
          ack_d = sda_sync;
          // Move the pointer now so rd_data_in settles before the next byte is latched.
          if (sda_sync == I2C_ACK) advance = 1'b1;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR: begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          bit_cnt_d = 3'd7;
          if (rw_q == I2C_WRITE) begin
            sda_oe_d = 1'b0;
            state_d  = PTR;
          end else begin
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d  = RDATA;
          end
        end
        PTR, WDATA: begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            if (ptr_valid_q) begin
              sda_oe_d = 1'b1;
              state_d  = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
              advance  = (state_q == WDATA);
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd7;
          state_d   = WDATA;
        end
        RDATA: begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = RDATA_ACK;
          end else begin
            tx_d      = {tx_q[6:0], 1'b1};
            sda_oe_d  = ~tx_q[6];
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        RDATA_ACK: begin
          if (ack_q == I2C_ACK) begin
            tx_d      = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 3'd7;
            state_d   = RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = IGNORE;
          end
        end
        default: ;
      endcase
    end

    if (advance && AUTOINC) begin
      reg_addr_d  = reg_addr_q + 8'd1;
      ptr_valid_d = ptr_valid_q && (reg_addr_q != LAST_PTR);
    end
  end

  assign sda              = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.reg_addr_out = reg_addr_q;
  assign bus.wr_data_out  = wr_data_q;
  assign bus.wr_valid_out = wr_valid_q;
  assign bus.busy_out     = busy_q;

endmodule
